// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a single-port data RAM, CPU-priority with a DMA starvation guard.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     cpu_wEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic [DATA_WIDTH-1:0]    cpu_dataOut,
  output logic                     cpu_stall,
  input  logic                     dma_req,
  input  logic                     dma_wEn,
  input  logic [ADDRESS_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]    dma_dataIn,
  output logic                     dma_ack,
  output logic                     dma_valid,
  output logic [DATA_WIDTH-1:0]    dma_dataOut,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);
  localparam logic [2:0] NONE   = 3'd0;
  localparam logic [2:0] CPU_RD = 3'd1;
  localparam logic [2:0] CPU_WR = 3'd2;
  localparam logic [2:0] DMA_RD = 3'd3;
  localparam logic [2:0] DMA_WR = 3'd4;
  logic [7:0]            starve_cnt;
  logic [2:0]            owner;
  logic [DATA_WIDTH-1:0] cpu_hold;
  logic                  force_dma, grant_cpu, grant_dma;
  // grants are gated by reset so every combinational output is quiet while reset is held
  always_comb begin
    force_dma   = dma_req && starve_cnt == 8'(STARVE_LIMIT);
    grant_dma   = reset && dma_req && (!cpu_en || force_dma);
    grant_cpu   = reset && cpu_en && !force_dma;
    dma_ack     = grant_dma;
    cpu_stall   = reset && cpu_en && force_dma;
    mem_wEn     = grant_dma ? dma_wEn : grant_cpu && cpu_wEn;
    mem_addr    = grant_dma ? dma_addr : grant_cpu ? cpu_addr : '0;
    mem_dataIn  = grant_dma ? dma_dataIn : grant_cpu ? cpu_dataIn : '0;
    dma_valid   = owner == DMA_RD;
    dma_dataOut = dma_valid ? mem_dataOut : '0;
    cpu_dataOut = owner == CPU_RD ? mem_dataOut : cpu_hold;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      starve_cnt <= '0;
      owner      <= NONE;
      cpu_hold   <= '0;
    end else begin
      starve_cnt <= (!dma_req || grant_dma) ? '0 : starve_cnt + 8'(starve_cnt != 8'(STARVE_LIMIT));
      owner      <= grant_dma ? (dma_wEn ? DMA_WR : DMA_RD) : grant_cpu ? (cpu_wEn ? CPU_WR : CPU_RD) : NONE;
      if (owner == CPU_RD) cpu_hold <= mem_dataOut;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed scoreboard bench for dmem_arbiter against a RAM and array reference model.
module tb_dmem_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 4;
  logic          clock = 1'b0, reset = 1'b0;
  logic          cpu_en = 1'b0, cpu_wEn = 1'b0, dma_req = 1'b0, dma_wEn = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_dataIn = '0, dma_dataIn = '0;
  logic [DW-1:0] cpu_dataOut, dma_dataOut, mem_dataIn, mem_dataOut;
  logic          cpu_stall, dma_ack, dma_valid, mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] mdl [0:(1<<AW)-1] = '{default: '0};
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  typedef struct { logic ack; logic stall; } ct_t;
  rd_t cpu_q[$], dma_q[$];
  ct_t ctl_q[$];
  int vec = 0, errs = 0, cyc = 0, cnt = 0;
  logic [DW-1:0] exp_cpu = '0;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .cpu_en(cpu_en), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
    .cpu_dataOut(cpu_dataOut), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wEn(dma_wEn), .dma_addr(dma_addr), .dma_dataIn(dma_dataIn),
    .dma_ack(dma_ack), .dma_valid(dma_valid), .dma_dataOut(dma_dataOut),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clock = ~clock;

  // synchronous RAM with one-cycle read latency
  always @(posedge clock) begin
    if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    mem_dataOut <= ram[mem_addr];
  end

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // drive one cycle of requests and predict the arbitration outcome from the rules
  task automatic step(input logic ce, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      output logic gd, output logic st);
    logic frc, gc;
    @(posedge clock);
    cyc++;
    #1;
    cpu_en = ce; cpu_wEn = cw; cpu_addr = ca; cpu_dataIn = cd;
    dma_req = dr; dma_wEn = dw; dma_addr = da; dma_dataIn = dd;
    frc = dr && cnt == LIM;
    gd  = dr && (!ce || frc);
    gc  = ce && !frc;
    st  = ce && frc;
    ctl_q.push_back('{gd, st});
    if (gc) begin
      if (cw) mdl[ca] = cd;
      else cpu_q.push_back('{cyc + 1, mdl[ca]});
    end
    if (gd) begin
      if (dw) mdl[da] = dd;
      else dma_q.push_back('{cyc + 1, mdl[da]});
    end
    cnt = (!dr || gd) ? 0 : (cnt < LIM ? cnt + 1 : cnt);
  endtask

  task automatic idle();
    logic g, s;
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g, s);
  endtask

  // monitor: compares DUT outputs against the scoreboard queues every cycle
  initial forever begin
    ct_t c;
    rd_t r;
    @(negedge clock);
    if (!reset) begin
      exp_cpu = '0;
      chk("rst_ack", DW'(dma_ack), '0);
      chk("rst_stall", DW'(cpu_stall), '0);
      chk("rst_mem_wEn", DW'(mem_wEn), '0);
      chk("rst_valid", DW'(dma_valid), '0);
      chk("rst_cpu_dataOut", cpu_dataOut, '0);
    end else begin
      c = ctl_q.size() != 0 ? ctl_q.pop_front() : '{1'b0, 1'b0};
      chk("dma_ack", DW'(dma_ack), DW'(c.ack));
      chk("cpu_stall", DW'(cpu_stall), DW'(c.stall));
      if (dma_q.size() != 0 && dma_q[0].due == cyc) begin
        r = dma_q.pop_front();
        chk("dma_valid", DW'(dma_valid), DW'(1'b1));
        chk("dma_dataOut", dma_dataOut, r.d);
      end else begin
        chk("dma_valid_idle", DW'(dma_valid), '0);
        chk("dma_dataOut_idle", dma_dataOut, '0);
      end
      if (cpu_q.size() != 0 && cpu_q[0].due == cyc) exp_cpu = cpu_q.pop_front().d;
      chk("cpu_dataOut", cpu_dataOut, exp_cpu);
    end
  end

  initial begin
    logic g, s, pd, pw, ce, cw;
    logic [AW-1:0] pa, ca;
    logic [DW-1:0] pdat, cd;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    // CPU write then read; DMA inputs toggled while dma_req=0 must be ignored
    step(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, g, s);
    step(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b1, 12'h3FF, 32'h1, g, s);
    step(1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0, 1'b0, '0, '0, g, s);
    // idle DMA read
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h020, '0, g, s);
    idle();
    // starvation: forced grant on cycle 5 and again on cycle 10
    repeat (10) step(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0, g, s);
    idle();
    // streaming DMA reads
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, AW'(12'h100 + i), 32'hC0DE0000 + DW'(i), 1'b0, 1'b0, '0, '0, g, s);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(12'h100 + i), '0, g, s);
    idle();
    // simultaneous writes: CPU first, DMA lands later and wins
    step(1'b1, 1'b1, 12'h030, 32'hAAAA0000, 1'b1, 1'b1, 12'h030, 32'h5555FFFF, g, s);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h030, 32'h5555FFFF, g, s);
    step(1'b1, 1'b0, 12'h030, '0, 1'b0, 1'b0, '0, '0, g, s);
    idle();
    // reset asserted between a DMA read grant and its edge
    step(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0, g, s);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h020, '0, g, s);
    @(negedge clock);
    #2 reset = 1'b0;
    cpu_en = 1'b1; cpu_wEn = 1'b1; dma_req = 1'b1;
    dma_q.delete(); cpu_q.delete(); cnt = 0;
    #1;
    chk("async_ack", DW'(dma_ack), '0);
    chk("async_stall", DW'(cpu_stall), '0);
    chk("async_mem_wEn", DW'(mem_wEn), '0);
    chk("async_valid", DW'(dma_valid), '0);
    chk("async_dma_dataOut", dma_dataOut, '0);
    chk("async_cpu_dataOut", cpu_dataOut, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cpu_en = 1'b0; cpu_wEn = 1'b0; dma_req = 1'b0;
    // randomized traffic; DMA holds its request until acknowledged, CPU holds while stalled
    pd = 1'b0; pw = 1'b0; pa = '0; pdat = '0; s = 1'b0;
    ce = 1'b0; cw = 1'b0; ca = '0; cd = '0;
    repeat (600) begin
      if (!pd && $urandom_range(0, 2) == 0) begin
        pd = 1'b1; pw = 1'($urandom); pa = AW'($urandom_range(0, 15)); pdat = $urandom;
      end
      if (!s) begin
        ce = $urandom_range(0, 3) != 0; cw = 1'($urandom); ca = AW'($urandom_range(0, 15)); cd = $urandom;
      end
      step(ce, cw, ca, cd, pd, pw, pd ? pa : AW'($urandom), pd ? pdat : $urandom, g, s);
      if (g) pd = 1'b0;
    end
    repeat (3) idle();
    @(negedge clock);
    #1 chk("drain", DW'(cpu_q.size() + dma_q.size() + ctl_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, data-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data-memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, number of consecutive denied DMA-request cycles before DMA is forced through; legal range 1..255.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports cpu_en (input, 1, CPU access this cycle), cpu_wEn (input, 1, CPU write), cpu_addr (input, ADDRESS_WIDTH), cpu_dataIn (input, DATA_WIDTH).
REQ-007 SHALL have ports cpu_dataOut (output, DATA_WIDTH, read data) and cpu_stall (output, 1, CPU access denied this cycle; CPU holds its request).
REQ-008 SHALL have ports dma_req (input, 1), dma_wEn (input, 1), dma_addr (input, ADDRESS_WIDTH), dma_dataIn (input, DATA_WIDTH).
REQ-009 SHALL have ports dma_ack (output, 1, grant this cycle), dma_valid (output, 1, read data valid), dma_dataOut (output, DATA_WIDTH).
REQ-010 SHALL have ports mem_wEn (output, 1), mem_addr (output, ADDRESS_WIDTH), mem_dataIn (output, DATA_WIDTH) to the RAM, and mem_dataOut (input, DATA_WIDTH) from the RAM, whose read data appears one clock after the address edge.

Function
REQ-011 SHALL grant at most one requester per cycle; the grant decision is combinational from current inputs and registered state.
REQ-012 SHALL grant CPU when cpu_en=1, unless DMA is being forced (REQ-014).
REQ-013 SHALL grant DMA when dma_req=1 and cpu_en=0.
REQ-014 SHALL force a DMA grant when dma_req=1 and starve_cnt=STARVE_LIMIT; if cpu_en=1 in that cycle, cpu_stall=1, and cpu_stall=0 in all other cycles.
REQ-015 SHALL keep an 8-bit starve_cnt: cleared when dma_req=0 or DMA is granted; otherwise incremented while dma_req=1 and denied, saturating at STARVE_LIMIT.
REQ-016 SHALL drive mem_addr, mem_dataIn and mem_wEn from the granted requester (mem_wEn = granted wEn); with no grant, mem_wEn=0 and mem_addr/mem_dataIn=0.
REQ-017 SHALL assert dma_ack combinationally in exactly the cycle DMA is granted; the DMA source holds dma_req, dma_wEn, dma_addr and dma_dataIn stable until dma_ack, and a DMA write completes at that edge.
REQ-018 SHALL register the owner of each granted access as one of NONE, CPU_RD, CPU_WR, DMA_RD or DMA_WR, with NONE when no grant is made.
REQ-019 SHALL assert dma_valid for exactly one cycle when the registered owner is DMA_RD, with dma_dataOut = mem_dataOut in that cycle, and dma_dataOut = 0 otherwise.
REQ-020 SHALL drive cpu_dataOut = mem_dataOut when the registered owner is CPU_RD, and hold the last CPU read value otherwise.
REQ-021 SHALL support back-to-back DMA grants: acknowledged reads in consecutive cycles yield consecutive dma_valid pulses in order.
REQ-022 SHALL ignore dma_wEn, dma_addr and dma_dataIn while dma_req=0, and ignore cpu_wEn, cpu_addr and cpu_dataIn while cpu_en=0.

Reset
REQ-023 SHALL, while reset=0, force starve_cnt=0, registered owner=NONE, dma_valid=0, dma_dataOut=0, cpu_dataOut register=0, dma_ack=0, cpu_stall=0 and mem_wEn=0, independent of clock.
REQ-024 SHALL drop any DMA read that is in flight when reset asserts: no dma_valid after reset releases.
REQ-025 SHALL evaluate the first grant on the first rising edge after reset returns to 1.

Verification
REQ-026 CPU write then read: cpu_en=1, cpu_wEn=1, addr 0x010, data 0xDEADBEEF, then a read of 0x010 -> cpu_dataOut=0xDEADBEEF one cycle after the read, with dma_ack=0 throughout.
REQ-027 Idle DMA read: cpu_en=0, dma_req=1, dma_addr 0x020 holding 0x12345678 -> dma_ack=1 in the same cycle; next cycle dma_valid=1 and dma_dataOut=0x12345678.
REQ-028 Starvation: STARVE_LIMIT=4, cpu_en=1 and dma_req=1 held -> 4 denied cycles, then cycle 5 has dma_ack=1 and cpu_stall=1, and starve_cnt returns to 0.
REQ-029 Streaming: dma_req held with cpu_en=0 over addresses 0x100..0x103 -> 4 consecutive dma_ack and 4 consecutive dma_valid pulses, with data in address order.
REQ-030 Reset mid-read: DMA read acknowledged, reset=0 asserted before the next edge -> dma_valid stays 0, and all outputs take their REQ-023 values immediately.
REQ-031 Simultaneous writes: CPU writes 0xAAAA0000 and DMA writes 0x5555FFFF to 0x030 in the same cycle with starve_cnt<limit -> the CPU write lands; the DMA write lands on a later grant; a final read of 0x030 returns 0x5555FFFF.
